// File: rtl/polar_to_rect_pkg.sv
// Shared types and constants for the polar-to-rectangular CORDIC engine.
package polar_to_rect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCALE  = 2'd1,
        ST_ROTATE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int AMP_W     = 17;
    localparam int ANG_W     = 16;
    localparam int OUT_W     = 16;
    localparam int GAIN_FRAC = 15;
    localparam int ATAN_N    = 16;

    // 1/An for 16 micro-rotations, Q1.15
    localparam int CORDIC_GAIN_Q15 = 19898;

    // atan(2^-i) in binary-angle units (pi = 32768)
    localparam logic signed [ANG_W-1:0] ATAN_TAB [ATAN_N] = '{
        16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
        16'sd651,  16'sd326,  16'sd163,  16'sd81,
        16'sd41,   16'sd20,   16'sd10,   16'sd5,
        16'sd3,    16'sd1,    16'sd1,    16'sd0
    };

    // x/y width: magnitude plus one bit of CORDIC growth, guard bits, sign
    function automatic int xy_width(input int guard);
        return AMP_W + 1 + guard + 1;
    endfunction

endpackage

// File: rtl/polar_to_rect_cordic_rot_stage.sv
// One combinational CORDIC micro-rotation driven by the sign of the residual angle.
module polar_to_rect_cordic_rot_stage
    import polar_to_rect_pkg::*;
#(
    parameter int XY_W  = 21,
    parameter int IDX_W = 4
) (
    input  logic signed [XY_W-1:0]  x_i,
    input  logic signed [XY_W-1:0]  y_i,
    input  logic signed [ANG_W-1:0] z_i,
    input  logic        [IDX_W-1:0] i_i,
    output logic signed [XY_W-1:0]  x_o,
    output logic signed [XY_W-1:0]  y_o,
    output logic signed [ANG_W-1:0] z_o
);

    logic signed [XY_W-1:0]  x_sh;
    logic signed [XY_W-1:0]  y_sh;
    logic signed [ANG_W-1:0] ang;

    // Rotate toward zero residual angle; z wraps mod 2^16 by construction.
    always_comb begin
        x_sh = x_i >>> i_i;
        y_sh = y_i >>> i_i;
        ang  = ATAN_TAB[i_i];
        if (z_i[ANG_W-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + ang;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - ang;
        end
    end

endmodule

// File: rtl/polar_to_rect.sv
// Iterative CORDIC rotation: (amp, phase) -> (amp*cos, amp*sin), one transaction at a time.
module polar_to_rect
    import polar_to_rect_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic                    I_sys_clk,
    input  logic                    I_sys_rstn,
    input  logic                    I_valid,
    output logic                    O_ready,
    input  logic [AMP_W-1:0]        I_amp,
    input  logic [ANG_W-1:0]        I_phase,
    output logic                    O_valid,
    input  logic                    I_ready,
    output logic signed [OUT_W-1:0] O_a1,
    output logic signed [OUT_W-1:0] O_a2,
    output logic                    O_sat
);

    localparam int XY_W     = xy_width(GUARD);
    localparam int IDX_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int CNT_W    = $clog2(ITER + 1);
    localparam int PROD_W   = AMP_W + GAIN_FRAC;
    localparam int RND_W    = XY_W + 1;
    localparam int RND_HALF = (GUARD > 0) ? (1 << (GUARD - 1)) : 0;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(32767);
    localparam logic signed [RND_W-1:0] SAT_MIN = -RND_W'(32768);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [AMP_W-1:0]        amp_q;
    logic [ANG_W-1:0]        phase_q;
    logic signed [XY_W-1:0]  x_q, y_q;
    logic signed [ANG_W-1:0] z_q;
    logic signed [OUT_W-1:0] a1_q, a2_q;
    logic                    sat_q, valid_q;

    logic [PROD_W-1:0]       prod_d;
    logic signed [XY_W-1:0]  x0_d;
    logic signed [ANG_W-1:0] z0_d;
    logic signed [XY_W-1:0]  x_d, y_d;
    logic signed [ANG_W-1:0] z_d;
    logic [OUT_W:0]          rs1_d, rs2_d;

    // Round half up, then clip to the 16-bit range; MSB of the result flags a clip.
    function automatic logic [OUT_W:0] round_sat(input logic signed [XY_W-1:0] v);
        logic signed [RND_W-1:0] r;
        r = (RND_W'(v) + RND_W'(RND_HALF)) >>> GUARD;
        if (r > SAT_MAX)      return {1'b1, 16'h7FFF};
        else if (r < SAT_MIN) return {1'b1, 16'h8000};
        else                  return {1'b0, r[OUT_W-1:0]};
    endfunction

    // Pre-scale by 1/An and fold phases outside [-pi/2, pi/2) by starting on the -x axis.
    always_comb begin
        prod_d = PROD_W'(amp_q) * PROD_W'(CORDIC_GAIN_Q15);
        x0_d   = XY_W'(prod_d >> (GAIN_FRAC - GUARD));
        z0_d   = phase_q;
        if (phase_q[ANG_W-1] != phase_q[ANG_W-2]) begin
            x0_d = -x0_d;
            z0_d = phase_q + 16'h8000;
        end
    end

    polar_to_rect_cordic_rot_stage #(
        .XY_W  (XY_W),
        .IDX_W (IDX_W)
    ) u_rot (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .i_i (cnt_q[IDX_W-1:0]),
        .x_o (x_d),
        .y_o (y_d),
        .z_o (z_d)
    );

    // Output quantisation of the fully rotated vector.
    always_comb begin
        rs1_d = round_sat(x_q);
        rs2_d = round_sat(y_q);
    end

    // Control FSM and datapath registers; the last ROTATE cycle rounds the settled x/y
    // into the output register after all ITER micro-rotations have been applied.
    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            amp_q   <= '0;
            phase_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (I_valid) begin
                        amp_q   <= I_amp;
                        phase_q <= I_phase;
                        state_q <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    x_q     <= x0_d;
                    y_q     <= '0;
                    z_q     <= z0_d;
                    cnt_q   <= '0;
                    state_q <= ST_ROTATE;
                end
                ST_ROTATE: begin
                    if (cnt_q == CNT_W'(ITER)) begin
                        a1_q    <= rs1_d[OUT_W-1:0];
                        a2_q    <= rs2_d[OUT_W-1:0];
                        sat_q   <= rs1_d[OUT_W] | rs2_d[OUT_W];
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        z_q   <= z_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (I_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign O_ready = (state_q == ST_IDLE);
    assign O_valid = valid_q;
    assign O_a1    = a1_q;
    assign O_a2    = a2_q;
    assign O_sat   = sat_q;

endmodule

// File: tb/tb_polar_to_rect.sv
// Self-checking bench for polar_to_rect: real-valued trig model plus directed vectors.
module tb_polar_to_rect;

    localparam int  ITER  = 16;
    localparam int  GUARD = 2;
    localparam int  LAT   = ITER + 2;
    localparam int  GAP   = ITER + 3;
    localparam real PI    = 3.14159265358979323846;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               I_valid = 1'b0;
    logic               I_ready = 1'b1;
    logic [16:0]        I_amp   = '0;
    logic [15:0]        I_phase = '0;
    logic               O_ready, O_valid, O_sat;
    logic signed [15:0] O_a1, O_a2;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          amp;
        logic [15:0] ph;
        int          acc;
    } txn_t;
    txn_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    polar_to_rect #(.ITER(ITER), .GUARD(GUARD)) dut (
        .I_sys_clk  (clk),
        .I_sys_rstn (rst_n),
        .I_valid    (I_valid),
        .O_ready    (O_ready),
        .I_amp      (I_amp),
        .I_phase    (I_phase),
        .O_valid    (O_valid),
        .I_ready    (I_ready),
        .O_a1       (O_a1),
        .O_a2       (O_a2),
        .O_sat      (O_sat)
    );

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Ideal component: amp*cos(phi) or amp*sin(phi), phi = signed phase * pi/32768
    function automatic real ideal(input int amp, input logic [15:0] ph, input bit want_sin);
        int  s;
        real ang;
        s   = int'($signed(ph));
        ang = real'(s) * PI / 32768.0;
        if (want_sin) return real'(amp) * $sin(ang);
        return real'(amp) * $cos(ang);
    endfunction

    function automatic int clampr(input real v);
        if (v >= 32767.0)  return 32767;
        if (v <= -32768.0) return -32768;
        return $rtoi($floor(v + 0.5));
    endfunction

    // Accuracy envelope: a few LSB of datapath rounding plus the residual angle
    // error left by the integer angle table, which scales with amplitude.
    function automatic int tol(input int amp);
        return 4 + amp / 3072;
    endfunction

    // 1 = must clip, 0 = must not clip, -1 = too close to full scale to call.
    function automatic int sat_exp(input int amp, input logic [15:0] ph);
        real c, s, t;
        bit  def_c, def_s, clr_c, clr_s;
        c = ideal(amp, ph, 1'b0);
        s = ideal(amp, ph, 1'b1);
        t = real'(tol(amp));
        def_c = (c > 32767.5 + t) || (c < -32768.5 - t);
        def_s = (s > 32767.5 + t) || (s < -32768.5 - t);
        clr_c = (c < 32767.5 - t) && (c > -32768.5 + t);
        clr_s = (s < 32767.5 - t) && (s > -32768.5 + t);
        if (def_c || def_s) return 1;
        if (clr_c && clr_s) return 0;
        return -1;
    endfunction

    // Compare process: latency, hold stability, ready/valid exclusivity, result vs model.
    initial begin : monitor
        bit                 prev_hold;
        logic signed [15:0] h_a1, h_a2;
        logic               h_sat;
        int                 last_acc;
        int                 t, e1, e2, se;
        prev_hold = 1'b0;
        h_a1      = '0;
        h_a2      = '0;
        h_sat     = 1'b0;
        last_acc  = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_hold = 1'b0;
                last_acc  = -1;
            end else begin
                if (O_valid) begin
                    check(O_ready == 1'b0, "ready_low_while_valid", int'(O_ready), 0);
                    if (!prev_hold) begin
                        if (sb.size() == 0) check(1'b0, "spurious_valid", 1, 0);
                        else check(cyc - sb[0].acc == LAT, "latency", cyc - sb[0].acc, LAT);
                    end else begin
                        check(O_a1 == h_a1, "hold_a1", int'(O_a1), int'(h_a1));
                        check(O_a2 == h_a2, "hold_a2", int'(O_a2), int'(h_a2));
                        check(O_sat == h_sat, "hold_sat", int'(O_sat), int'(h_sat));
                    end
                    h_a1  = O_a1;
                    h_a2  = O_a2;
                    h_sat = O_sat;
                    if (I_ready && sb.size() > 0) begin
                        t  = tol(sb[0].amp);
                        e1 = clampr(ideal(sb[0].amp, sb[0].ph, 1'b0));
                        e2 = clampr(ideal(sb[0].amp, sb[0].ph, 1'b1));
                        se = sat_exp(sb[0].amp, sb[0].ph);
                        check(iabs(int'(O_a1) - e1) <= t, "model_a1", int'(O_a1), e1);
                        check(iabs(int'(O_a2) - e2) <= t, "model_a2", int'(O_a2), e2);
                        if (se >= 0) check(int'(O_sat) == se, "model_sat", int'(O_sat), se);
                        void'(sb.pop_front());
                    end
                end
                if (I_valid && O_ready) begin
                    if (last_acc >= 0)
                        check(cyc + 1 - last_acc >= GAP, "accept_gap", cyc + 1 - last_acc, GAP);
                    last_acc = cyc + 1;
                    sb.push_back('{amp: int'(I_amp), ph: I_phase, acc: cyc + 1});
                end
                prev_hold = O_valid && !I_ready;
            end
        end
    end

    task automatic send(input int amp, input logic [15:0] ph);
        int n;
        n = 0;
        while (!O_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!O_ready) check(1'b0, "ready_timeout", 0, 1);
        I_valid = 1'b1;
        I_amp   = 17'(amp);
        I_phase = ph;
        @(posedge clk); #1;
        I_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int n = 0; n < 4 * LAT && !got; n++) begin
            @(negedge clk);
            if (O_valid) got = 1'b1;
        end
        if (!got) check(1'b0, "valid_timeout", 0, 1);
    endtask

    task automatic run_dir(input string name, input int amp, input logic [15:0] ph,
                           input int e1, input int e2, input bit es, input int t1, input int t2);
        bit got;
        send(amp, ph);
        wait_valid(got);
        if (got) begin
            check(iabs(int'(O_a1) - e1) <= t1, {name, "_a1"}, int'(O_a1), e1);
            check(iabs(int'(O_a2) - e2) <= t2, {name, "_a2"}, int'(O_a2), e2);
            check(O_sat == es, {name, "_sat"}, int'(O_sat), int'(es));
        end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        bit                 got;
        logic signed [15:0] s_a1, s_a2;
        logic               s_sat;
        int                 amp;
        logic [15:0]        ph;

        // Reset state, with a stray request that must not be captured
        I_valid = 1'b1;
        I_amp   = 17'd1234;
        repeat (3) @(posedge clk);
        #1;
        check(O_valid == 1'b0, "rst_valid", int'(O_valid), 0);
        check(O_a1 == 16'sd0, "rst_a1", int'(O_a1), 0);
        check(O_a2 == 16'sd0, "rst_a2", int'(O_a2), 0);
        check(O_sat == 1'b0, "rst_sat", int'(O_sat), 0);
        check(O_ready == 1'b1, "rst_ready", int'(O_ready), 1);
        I_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check(O_valid == 1'b0, "no_capture_in_reset", int'(O_valid), 0);

        // Pin the model to hand-computed values
        check(clampr(ideal(10000, 16'h0000, 1'b0)) == 10000, "pin_cos_0", clampr(ideal(10000, 16'h0000, 1'b0)), 10000);
        check(clampr(ideal(10000, 16'h4000, 1'b1)) == 10000, "pin_sin_90", clampr(ideal(10000, 16'h4000, 1'b1)), 10000);
        check(clampr(ideal(20000, 16'h8000, 1'b0)) == -20000, "pin_cos_180", clampr(ideal(20000, 16'h8000, 1'b0)), -20000);
        check(clampr(ideal(46000, 16'hE000, 1'b0)) == 32527, "pin_cos_m45", clampr(ideal(46000, 16'hE000, 1'b0)), 32527);
        check(clampr(ideal(46000, 16'hE000, 1'b1)) == -32527, "pin_sin_m45", clampr(ideal(46000, 16'hE000, 1'b1)), -32527);
        check(clampr(ideal(5000, 16'h2000, 1'b0)) == 3536, "pin_cos_45", clampr(ideal(5000, 16'h2000, 1'b0)), 3536);
        check(sat_exp(60000, 16'h0000) == 1, "pin_sat_60000", sat_exp(60000, 16'h0000), 1);

        // Directed vectors
        run_dir("p0",     10000, 16'h0000, 10000,  0,      1'b0, tol(10000), tol(10000));
        run_dir("p90",    10000, 16'h4000, 0,      10000,  1'b0, tol(10000), tol(10000));
        run_dir("p180",   20000, 16'h8000, -20000, 0,      1'b0, tol(20000), tol(20000));
        run_dir("sat",    60000, 16'h0000, 32767,  0,      1'b1, 0,          tol(60000));
        run_dir("m45",    46000, 16'hE000, 32527,  -32527, 1'b0, tol(46000), tol(46000));
        run_dir("zero",   0,     16'h5A5A, 0,      0,      1'b0, 0,          0);

        // Back-pressure: result held for 7 cycles, busy requests ignored
        I_ready = 1'b0;
        send(30000, 16'h1000);
        repeat (5) @(posedge clk);
        #1;
        check(O_ready == 1'b0, "busy_ready_low", int'(O_ready), 0);
        I_valid = 1'b1;
        I_amp   = 17'd777;
        I_phase = 16'h7777;
        @(posedge clk); #1;
        I_valid = 1'b0;
        wait_valid(got);
        s_a1  = O_a1;
        s_a2  = O_a2;
        s_sat = O_sat;
        @(posedge clk); #1;
        for (int n = 0; n < 7; n++) begin
            if (n == 3) I_valid = 1'b1;
            @(negedge clk);
            check(O_valid == 1'b1, "held_valid", int'(O_valid), 1);
            check(O_ready == 1'b0, "held_ready", int'(O_ready), 0);
            check(O_a1 == s_a1 && O_a2 == s_a2 && O_sat == s_sat, "held_bits", int'(O_a1), int'(s_a1));
            @(posedge clk); #1;
            I_valid = 1'b0;
        end
        I_ready = 1'b1;
        @(posedge clk); #1;
        check(O_valid == 1'b0, "release_valid", int'(O_valid), 0);
        check(O_ready == 1'b1, "release_ready", int'(O_ready), 1);

        // Reset during ROTATE iteration 8 aborts the transaction
        send(10000, 16'h1234);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check(O_valid == 1'b0, "abort_valid", int'(O_valid), 0);
        check(O_ready == 1'b1, "abort_ready", int'(O_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        check(O_valid == 1'b0, "abort_no_result", int'(O_valid), 0);
        check(O_ready == 1'b1, "abort_idle", int'(O_ready), 1);
        run_dir("p45", 5000, 16'h2000, 3536, 3536, 1'b0, tol(5000), tol(5000));

        // Random vectors at full throughput, checked by the model
        for (int v = 0; v < 1500; v++) begin
            if ($urandom_range(0, 9) < 7) amp = int'($urandom_range(0, 32767));
            else                          amp = int'($urandom_range(0, 131071));
            ph = 16'($urandom);
            send(amp, ph);
        end
        repeat (LAT + 6) @(posedge clk);
        #1;
        check(sb.size() == 0, "drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
